// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_pkg
//  Description : Shared types and constants for the BCD seven-segment scanner:
//                converter state encoding, segment lookup and blank pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package sevseg_pkg;

  // Serial double-dabble converter states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low g..a patterns; entry [n] is the glyph for nibble n.
  // Non-decimal nibbles render as blank.
  localparam logic [15:0][6:0] SEG_LUT = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, // 15..10
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_serial.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_serial
//  Description : Serial binary-to-BCD converter (double-dabble), one bit per
//                clock. WIDTH shift cycles followed by one DONE cycle in which
//                the finished result is presented on bcd with done high.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_serial
  import sevseg_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  conv_state_e              state_q;
  logic [WIDTH-1:0]         shift_q;
  logic [BCD_W-1:0]         scratch_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [BCD_W-1:0]         adj_d;
  logic [BCD_W+WIDTH-1:0]   cat_d;

  // Add 3 to every scratch nibble that is 5 or more before the shift
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign adj_d[i*4 +: 4] = (scratch_q[i*4 +: 4] >= 4'd5) ?
                               scratch_q[i*4 +: 4] + 4'd3 : scratch_q[i*4 +: 4];
    end
  endgenerate

  // {scratch, shift register} moves left by one, MSB of the binary first
  assign cat_d = {adj_d, shift_q} << 1;

  // Converter FSM: latch on start, WIDTH shifts, one DONE cycle, back to IDLE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch_q <= cat_d[BCD_W+WIDTH-1:WIDTH];
          shift_q   <= cat_d[WIDTH-1:0];
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign bcd  = scratch_q;

endmodule
`default_nettype wire

// File: rtl/bcd_sevseg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_sevseg_scan
//  Description : Converts a binary PIO value to BCD whenever it changes and
//                time-multiplexes the digits onto a common seven-segment bus
//                with optional leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_sevseg_scan
  import sevseg_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int LZB         = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   in_value,
  output logic [6:0]         seg_n,
  output logic [DIGITS-1:0]  dig_n,
  output logic               busy
);

  localparam int BCD_W = DIGITS * 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [WIDTH-1:0]   last_value_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [PRE_W-1:0]   pre_q;
  logic [IDX_W-1:0]   idx_q;
  logic [6:0]         seg_q;
  logic [DIGITS-1:0]  dig_q;

  logic               start_d;
  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;
  logic [DIGITS-1:0]  lead_zero_d;
  logic [3:0]         nib_d;
  logic               blank_d;

  // A change is only acted on while the converter is idle; a change seen
  // mid-conversion stays pending because last_value still differs.
  assign start_d = !conv_busy && (in_value != last_value_q);

  bin2bcd_serial #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_d),
    .bin     (in_value),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Track the converted value; the display copy changes only on DONE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_value_q <= '0;
      bcd_q        <= '0;
    end else begin
      if (start_d)   last_value_q <= in_value;
      if (conv_done) bcd_q        <= conv_bcd;
    end
  end

  // lead_zero_d[i]: nibbles i..DIGITS-1 are all zero
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_lzb
      assign lead_zero_d[i] = (bcd_q[BCD_W-1:i*4] == '0);
    end
  endgenerate

  assign nib_d   = bcd_q[int'(idx_q)*4 +: 4];
  assign blank_d = (LZB != 0) && (idx_q != '0) && lead_zero_d[idx_q];

  // Refresh prescaler and digit index rotation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Registered digit enable and matching segment pattern
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q <= SEG_BLANK;
      dig_q <= '1;
    end else begin
      seg_q <= blank_d ? SEG_BLANK : seg_decode(nib_d);
      dig_q <= ~(DIGITS'(1) << idx_q);
    end
  end

  assign seg_n = seg_q;
  assign dig_n = dig_q;
  assign busy  = conv_busy;

endmodule
`default_nettype wire

// File: tb/tb_bcd_sevseg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_sevseg_scan
//  Description : Directed self-checking bench for bcd_sevseg_scan; expected
//                BCD results are queued when a value is driven and popped when
//                a conversion completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_sevseg_scan;

  localparam logic [6:0] S_BLANK = 7'h7F;
  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_3 = 7'b0110000;
  localparam logic [6:0] S_4 = 7'b0011001;
  localparam logic [6:0] S_5 = 7'b0010010;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_value = 4'd4;
  logic [6:0] seg_a, seg_b;
  logic [1:0] dig_a, dig_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_sevseg_scan #(.WIDTH(4), .DIGITS(2), .REFRESH_DIV(4), .LZB(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_value(in_value),
    .seg_n(seg_a), .dig_n(dig_a), .busy(busy_a));

  bcd_sevseg_scan #(.WIDTH(4), .DIGITS(2), .REFRESH_DIV(4), .LZB(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_value(in_value),
    .seg_n(seg_b), .dig_n(dig_b), .busy(busy_b));

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens, ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a conversion to start and finish, then score its result
  task automatic wait_done(output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    while (busy_a !== 1'b1 && n < 50) begin tick(); n++; end
    chk("conv_start", 32'(busy_a), 32'd1);
    while (busy_a === 1'b1 && busy_cycles < 50) begin busy_cycles++; tick(); end
    chk("conv_end", 32'(busy_a), 32'd0);
    chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) chk("bcd_q", 32'(dut_a.bcd_q), 32'(exp_q.pop_front()));
  endtask

  // Wait for digit idx to be enabled on the chosen instance and check its glyph
  task automatic check_digit(input bit use_b, input int idx, input logic [6:0] exp,
                             input string tag);
    logic [1:0] want;
    bit found;
    want = 2'b11;
    want[idx] = 1'b0;
    found = 1'b0;
    tick();
    for (int n = 0; n < 40 && !found; n++) begin
      if ((use_b ? dig_b : dig_a) === want) found = 1'b1;
      else tick();
    end
    chk({tag, "_enabled"}, 32'(found), 32'd1);
    chk(tag, 32'(use_b ? seg_b : seg_a), 32'(exp));
  endtask

  initial begin
    int bc, n, len, hits;

    // Reset with the PIO reset value present
    in_value = 4'd4;
    reset_n  = 1'b0;
    repeat (3) tick();
    chk("rst_seg", 32'(seg_a), 32'(S_BLANK));
    chk("rst_dig", 32'(dig_a), 32'd3);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_bcd", 32'(dut_a.bcd_q), 32'd0);

    // Release: value 4 differs from 0, one conversion of WIDTH+1 busy cycles
    reset_n = 1'b1;
    exp_q.push_back(to_bcd(4));
    wait_done(bc);
    chk("busy_len_4", 32'(bc), 32'd5);
    check_digit(1'b0, 0, S_4, "d0_4");
    check_digit(1'b0, 1, S_BLANK, "d1_4_blank");

    // 4 -> 15 and scan timing
    in_value = 4'd15;
    exp_q.push_back(to_bcd(15));
    wait_done(bc);
    chk("busy_len_15", 32'(bc), 32'd5);
    check_digit(1'b0, 0, S_5, "d0_15");
    check_digit(1'b0, 1, S_1, "d1_15");
    n = 0;
    while (dig_a !== 2'b01 && n < 40) begin tick(); n++; end
    n = 0;
    while (dig_a !== 2'b10 && n < 40) begin tick(); n++; end
    len = 0;
    while (dig_a === 2'b10 && len < 40) begin len++; tick(); end
    chk("slot_len", 32'(len), 32'd4);
    chk("slot_next", 32'(dig_a), 32'd1);

    // 9 then 12 arriving in the second SHIFT cycle
    in_value = 4'd9;
    exp_q.push_back(to_bcd(9));
    n = 0;
    while (busy_a !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    in_value = 4'd12;
    exp_q.push_back(to_bcd(12));
    wait_done(bc);
    wait_done(bc);
    chk("busy_len_12", 32'(bc), 32'd5);
    check_digit(1'b0, 0, S_2, "d0_12");
    check_digit(1'b0, 1, S_1, "d1_12");

    // Reset during SHIFT abandons the conversion
    in_value = 4'd3;
    n = 0;
    while (busy_a !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_seg", 32'(seg_a), 32'(S_BLANK));
    chk("mid_rst_dig", 32'(dig_a), 32'd3);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_bcd", 32'(dut_a.bcd_q), 32'd0);
    reset_n = 1'b1;
    exp_q.push_back(to_bcd(3));
    wait_done(bc);
    chk("busy_len_3", 32'(bc), 32'd5);
    check_digit(1'b0, 0, S_3, "d0_3");
    check_digit(1'b0, 1, S_BLANK, "d1_3_lzb1");
    check_digit(1'b1, 1, S_0, "d1_3_lzb0");

    // Steady input: no conversions, value stays put
    hits = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (busy_a !== 1'b0) hits++;
    end
    chk("steady_busy", 32'(hits), 32'd0);
    chk("steady_bcd", 32'(dut_a.bcd_q), 32'(to_bcd(3)));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_sevseg_scan.md
BCD_SEVSEG_SCAN -- requirements
Module: bcd_sevseg_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 4, binary input width in bits.
REQ-002 SHALL have parameter DIGITS, default 2, number of display digits; DIGITS*4 SHALL be large enough for the full BCD value of 2^WIDTH-1.
REQ-003 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz).
REQ-004 SHALL have parameter LZB, default 1, leading-zero blanking enable.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge system clock.
REQ-007 reset_n  input  1  synchronous active-low reset.
REQ-008 in_value  input  WIDTH  binary value, driven directly by the LED/PIO register out_port.
REQ-009 seg_n  output  7  segments g..a, active-low, registered.
REQ-010 dig_n  output  DIGITS  digit enables, active-low one-hot, registered.
REQ-011 busy  output  1  high while a conversion is in progress.

Function
REQ-012 SHALL hold last_value (WIDTH bits) and bcd_q (DIGITS*4 bits), both reset to 0.
REQ-013 Converter FSM states SHALL be IDLE, SHIFT and DONE; reset state SHALL be IDLE.
REQ-014 IDLE: if in_value != last_value at edge k, SHALL latch in_value into the shift register and last_value, clear the BCD scratch, and enter SHIFT at edge k+1; otherwise SHALL remain in IDLE.
REQ-015 SHIFT SHALL run exactly WIDTH cycles; each cycle SHALL add 3 to every scratch nibble >=5 and then shift {scratch, shift reg} left by 1, MSB first (double-dabble).
REQ-016 After the WIDTH-th shift the FSM SHALL enter DONE; DONE SHALL write scratch to bcd_q and return to IDLE in one cycle, so bcd_q updates WIDTH+2 edges after detection.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 in_value changes during SHIFT/DONE SHALL be ignored until IDLE; the conversion in progress completes, and a new one starts on the first IDLE cycle, because last_value differs.
REQ-019 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count, digit index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-020 dig_n SHALL drive low only bit [index], registered one cycle after index changes; seg_n SHALL update on the same edge from nibble [index] of bcd_q.
REQ-021 Segment decoding: nibbles 0-9 SHALL use standard active-low 7-seg patterns (0 -> 7'b1000000, 1 -> 7'b1111001); nibbles 10-15 SHALL show blank (7'h7F).
REQ-022 With LZB=1, digit i>0 SHALL be blank when nibbles i..DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-023 bcd_q SHALL change only in DONE, so display never shows partial conversion results.

Reset
REQ-024 When reset_n is 0 at a clk edge: state=IDLE, last_value=0, bcd_q=0, prescaler=0, index=0, seg_n=7'h7F, dig_n all ones, busy=0.
REQ-025 Reset asserted mid-conversion SHALL abandon the conversion; after release, in_value SHALL be re-compared against 0. A PIO reset value of 4 therefore triggers one conversion.

Structure
REQ-026 Package sevseg_pkg SHALL hold the FSM state enum, the 16-entry segment lookup constant and the blank constant.
REQ-027 Converter SHALL be sub-module bin2bcd_serial (ports clk, reset_n, start, bin, busy, done, bcd); scan/decode logic SHALL stay in the top.

Verification
REQ-028 Reset with in_value=4, release -> busy high for WIDTH+1 cycles; bcd_q=8'h04; digit 0 shows 7'b0011001; digit 1 blank.
REQ-029 in_value 4->15, REFRESH_DIV=4 -> bcd_q=8'h15; dig_n cycles 2'b10, 2'b01 every 4 cycles; seg_n 7'b0010010 ("5"), 7'b1111001 ("1").
REQ-030 in_value 9->12 at the 2nd SHIFT cycle, then held -> first conversion yields 8'h09, second starts the next IDLE cycle, final bcd_q=8'h12.
REQ-031 Assert reset_n=0 during SHIFT -> next edge all outputs at reset values; after release, the current in_value is converted from scratch.
REQ-032 LZB=0, in_value=3 -> digit 1 shows "0" (7'b1000000); with LZB=1 digit 1 shows 7'h7F.
REQ-033 in_value held constant for 1000 cycles -> busy never asserts and bcd_q stays unchanged.
